mem_scan_reader: RTL and testbench
==================================

// Module: mem_scan_reader
// PURPOSE
//  Read-side sequencer for the switch-loaded 4x4 board memory.
//  On start, walks every address, issues a synchronous read and holds each word
//  on a valid/ready output until the consumer takes it.
//  Also drives a hex digit on the 7-segment display.
//  Sits between the memory read port and the LED/SEG/LCD debug outputs in top.
// PARAMETERS
//  ADDR_W       2  address width; DEPTH = 2**ADDR_W words
//  DATA_W       4  memory word width (one hex digit)
//  HOLD_CYCLES  1  minimum cycles each word stays valid (>=1)
// PORTS
//  clk_2      in   1       system clock; all state on posedge
//  reset      in   1       synchronous, active-high reset
//  start      in   1       begin one scan; ignored unless IDLE
//  continuous in   1       1: wrap to addr 0 after last word; 0: stop
//  mem_rd_en  out  1       read strobe to memory, one cycle per address
//  mem_addr   out  ADDR_W  read address
//  mem_rdata  in   DATA_W  read data, valid the cycle after mem_rd_en
//  out_valid  out  1       out_addr/out_data hold a word
//  out_ready  in   1       consumer accepts the word when high with out_valid
//  out_addr   out  ADDR_W  address of presented word
//  out_data   out  DATA_W  presented word
//  seg        out  8       [6:0] = hex of out_data (a=bit0..g=bit6), active-high; [7] = busy
//  busy       out  1       scan in progress (any state but IDLE)
//  done       out  1       one-cycle pulse when a non-continuous scan ends
// BEHAVIOUR
//  Reset (sync, high): state=IDLE; all outputs 0, seg=8'h00 (blank). Reset wins over every other input.
//  FSM: IDLE -> READ -> CAPT -> SHOW -> {READ | FIN}; FIN -> IDLE.
//  IDLE: start=1 -> mem_addr=0, READ. busy=0.
//  READ: mem_rd_en=1 for exactly this cycle, mem_addr stable. Next state is CAPT.
//  CAPT: latch mem_rdata->out_data, mem_addr->out_addr. Clear hold_cnt. Next state is SHOW.
//  SHOW: out_valid=1; hold_cnt increments, saturating at HOLD_CYCLES-1.
//    Exit when out_ready=1 AND hold_cnt==HOLD_CYCLES-1; out_valid drops on the exit edge.
//    Exit with mem_addr<DEPTH-1: mem_addr+1, go to READ.
//    Exit with mem_addr==DEPTH-1 and continuous=1 (sampled on this edge): mem_addr=0, go to READ.
//    Exit with mem_addr==DEPTH-1 and continuous=0: go to FIN.
//  FIN: done=1 for this cycle only; busy=1; next state is IDLE.
//  Backpressure: while out_ready=0 in SHOW, out_valid, out_addr and out_data are held and mem_rd_en stays 0.
//  out_data/out_addr keep their last value after a scan; seg keeps showing it.
//  seg shows blank only until the first CAPT after reset.
//  start while busy: no effect; no queued restart.
//  Latency: start at edge N -> mem_rd_en in cycle N+1 -> out_valid from cycle N+3.
//    With ready=1 and HOLD=1, each word takes 3 cycles; a DEPTH=4 scan takes 12 cycles + FIN.
//  Address arithmetic is ADDR_W bits; wrap is explicit, never overflow-dependent.
// STRUCTURE
//  Package mem_scan_pkg: state_t enum {IDLE,READ,CAPT,SHOW,FIN}; SEG_BLANK=8'h00; hex->7seg constant table.
//  Sub-module hex7seg: combinational DATA_W=4 -> 7-bit decode, instantiated once.
//  hold_cnt width: $clog2(HOLD_CYCLES+1).
// TESTING
//  Bench memory model: synchronous 1-cycle read.
//  1 reset held 2 cycles -> all outputs 0, seg=8'h00, busy=0.
//  2 mem={3,A,5,F}, HOLD=1, ready=1, pulse start
//    -> (addr,data) = (0,3),(1,A),(2,5),(3,F), each valid 1 cycle, 3 cycles apart
//    -> done one pulse, then busy=0.
//  3 ready=0 for 5 cycles while addr 1 is shown
//    -> out_valid=1 and out_data=A stable; mem_rd_en=0; resumes on ready=1.
//  4 continuous=1 -> after (3,F) next word is (0,3) and no done pulse
//    -> drop continuous: pass ends after addr 3 with done pulse.
//  5 start pulsed during SHOW -> ignored.
//    reset asserted in SHOW -> next cycle IDLE, all outputs 0.
//  6 seg decode: data 0 -> seg[6:0]=7'h3F; data A -> 7'h77; data F -> 7'h71; seg[7]==busy throughout.

Source files
------------

// File: rtl/mem_scan_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_scan_pkg
//  Brief    : Shared types and constants for the memory scan reader
//             (FSM state encoding, blank display code, hex-to-7-seg table).
//  Revision : 1.0  initial release
// ============================================================================
package mem_scan_pkg;

  // Scan sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    SHOW = 3'd3,
    FIN  = 3'd4
  } state_t;

  // Display code shown before any word has been captured
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high segment patterns, a=bit0 .. g=bit6; entry 15 listed first
  localparam logic [15:0][6:0] HEX7SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

endpackage : mem_scan_pkg
`default_nettype wire

// File: rtl/mem_scan_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_scan_reader_if
//  Brief    : Memory read port plus valid/ready word stream between the scan
//             reader (master) and the memory/consumer side (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface mem_scan_reader_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
);

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output mem_rd_en, mem_addr, out_valid, out_addr, out_data,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_addr, out_data,
    output mem_rdata, out_ready
  );

endinterface : mem_scan_reader_if
`default_nettype wire

// File: rtl/mem_scan_reader_hex7seg.sv
`default_nettype none
// ============================================================================
//  Module   : hex7seg
//  Brief    : Combinational hex digit to active-high 7-segment decode.
//  Revision : 1.0  initial release
// ============================================================================
module hex7seg
  import mem_scan_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segments
);

  // Table lookup of the segment pattern for one hex digit
  always_comb begin
    segments = HEX7SEG_TABLE[digit];
  end

endmodule : hex7seg
`default_nettype wire

// File: rtl/mem_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module   : mem_scan_reader
//  Brief    : Walks every memory address on start, issues a synchronous read,
//             presents each word on a valid/ready stream and shows it on a
//             7-segment digit. Optional continuous wrap-around scanning.
//  Revision : 1.0  initial release
// ============================================================================
module mem_scan_reader
  import mem_scan_pkg::*;
#(
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  mem_scan_reader_if.master   bus,
  output logic [7:0]          seg,
  output logic                busy,
  output logic                done
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              shown_q,    shown_d;   // a word has been captured since reset
  logic [6:0]        digit_seg;

  // State and datapath registers; reset clears everything including the display
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      hold_cnt_q <= '0;
      shown_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      hold_cnt_q <= hold_cnt_d;
      shown_q    <= shown_d;
    end
  end

  // Next-state and per-state strobes for the read/capture/show sequence
  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    out_addr_d    = out_addr_q;
    out_data_d    = out_data_q;
    hold_cnt_d    = hold_cnt_q;
    shown_d       = shown_q;
    bus.mem_rd_en = 1'b0;
    bus.out_valid = 1'b0;
    done          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mem_addr_d = '0;
          state_d    = READ;
        end
      end

      READ: begin
        bus.mem_rd_en = 1'b1;
        state_d       = CAPT;
      end

      CAPT: begin
        // Read data arrives the cycle after the strobe
        out_data_d = bus.mem_rdata;
        out_addr_d = mem_addr_q;
        hold_cnt_d = '0;
        shown_d    = 1'b1;
        state_d    = SHOW;
      end

      SHOW: begin
        bus.out_valid = 1'b1;
        if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        if (bus.out_ready && (hold_cnt_q == HOLD_MAX)) begin
          if (mem_addr_q != LAST_ADDR) begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = READ;
          end else if (continuous) begin
            // Explicit wrap rather than relying on counter overflow
            mem_addr_d = '0;
            state_d    = READ;
          end else begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  hex7seg u_hex7seg (
    .digit    (out_data_q[3:0]),
    .segments (digit_seg)
  );

  // Output drive: registered word, busy flag and display (blank until first capture)
  always_comb begin
    busy         = (state_q != IDLE);
    bus.mem_addr = mem_addr_q;
    bus.out_addr = out_addr_q;
    bus.out_data = out_data_q;
    seg          = SEG_BLANK;
    seg[7]       = busy;
    if (shown_q) begin
      seg[6:0] = digit_seg;
    end
  end

endmodule : mem_scan_reader
`default_nettype wire

// File: tb/tb_mem_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_scan_reader
//  Brief    : Self-checking bench for mem_scan_reader with a synchronous
//             memory model, a per-cycle behavioural checker and directed tests.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_scan_reader;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] seg;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mem_scan_reader_if #(.ADDR_W(2), .DATA_W(4)) bus ();

  assign bus.out_ready = ready;

  mem_scan_reader #(.ADDR_W(2), .DATA_W(4), .HOLD_CYCLES(1)) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .bus        (bus),
    .seg        (seg),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_2 = ~clk_2;
  always @(posedge clk_2) cyc <= cyc + 1;

  // Memory model: synchronous one-cycle read
  logic [3:0] mem [4];
  always @(posedge clk_2) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Independent segment table (a=bit0 .. g=bit6)
  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model and per-cycle compare ----------------
  int exp_addr  = 0;
  bit exp_done  = 0;
  bit prev_done = 0;
  bit seen_word = 0;
  int done_cnt  = 0;
  int log_addr[$];
  int log_data[$];
  int log_cyc[$];

  always @(negedge clk_2) begin
    if (reset) begin
      exp_addr  = 0;
      exp_done  = 0;
      prev_done = 0;
      seen_word = 0;
    end else begin
      chk("seg7_is_busy", 32'(seg[7]), 32'(busy));
      chk("done_pulse", 32'(done), 32'(exp_done));
      if (prev_done) chk("idle_after_done", 32'(busy), 0);
      if (bus.mem_rd_en) chk("no_read_while_valid", 32'(bus.out_valid), 0);
      if (bus.out_valid) begin
        seen_word = 1;
        chk("valid_word_data", 32'(bus.out_data), 32'(mem[bus.out_addr]));
      end
      if (seen_word) chk("seg_decode", 32'(seg[6:0]), 32'(seg_tbl[bus.out_data]));
      else if (!busy) chk("seg_blank", 32'(seg), 0);
      if (done) done_cnt++;
      prev_done = done;
      exp_done  = 0;
      if (bus.out_valid && bus.out_ready) begin
        chk("handshake_addr", 32'(bus.out_addr), 32'(exp_addr));
        log_addr.push_back(int'(bus.out_addr));
        log_data.push_back(int'(bus.out_data));
        log_cyc.push_back(cyc);
        if (exp_addr == 3 && !continuous) exp_done = 1;
        exp_addr = (exp_addr + 1) % 4;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!bus.out_valid && n < max) begin
      tick();
      n++;
    end
    chk("wait_valid_bound", 32'(bus.out_valid), 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    chk("wait_idle_bound", 32'(busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_seg"}, 32'(seg), 0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_rd_en"}, 32'(bus.mem_rd_en), 0);
    chk({tag, "_out_addr"}, 32'(bus.out_addr), 0);
    chk({tag, "_out_data"}, 32'(bus.out_data), 0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
  endtask

  initial begin
    int lb;
    int db;
    int exp_a [4] = '{0, 1, 2, 3};
    int exp_d [4] = '{4'h3, 4'hA, 4'h5, 4'hF};

    mem[0] = 4'h3; mem[1] = 4'hA; mem[2] = 4'h5; mem[3] = 4'hF;

    // 1: reset held two cycles
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // 2: full scan, ready always high
    lb = log_addr.size(); db = done_cnt;
    pulse_start();
    chk("latency_rd_en", 32'(bus.mem_rd_en), 1);
    chk("latency_mem_addr", 32'(bus.mem_addr), 0);
    tick();
    chk("capt_not_valid", 32'(bus.out_valid), 0);
    tick();
    chk("first_valid", 32'(bus.out_valid), 1);
    chk("first_addr", 32'(bus.out_addr), 0);
    chk("first_data", 32'(bus.out_data), 4'h3);
    chk("first_seg", 32'(seg), 8'hCF);
    wait_idle(60);
    chk("scan_words", 32'(log_addr.size() - lb), 4);
    if (log_addr.size() - lb == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("scan_addr", 32'(log_addr[lb+i]), 32'(exp_a[i]));
        chk("scan_data", 32'(log_data[lb+i]), 32'(exp_d[i]));
        if (i > 0) chk("scan_gap", 32'(log_cyc[lb+i] - log_cyc[lb+i-1]), 3);
      end
    end
    chk("scan_done_count", 32'(done_cnt - db), 1);
    chk("seg_after_scan", 32'(seg), 8'h71);

    // 3: backpressure on address 1
    lb = log_addr.size(); db = done_cnt;
    ready = 1'b0;
    pulse_start();
    wait_valid(20);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_addr", 32'(bus.out_addr), 1);
      chk("bp_data", 32'(bus.out_data), 4'hA);
      chk("bp_rd_en", 32'(bus.mem_rd_en), 0);
      chk("bp_seg", 32'(seg), 8'hF7);
    end
    ready = 1'b1;
    wait_idle(60);
    chk("bp_words", 32'(log_addr.size() - lb), 4);
    chk("bp_done_count", 32'(done_cnt - db), 1);

    // 4: continuous wrap, then stop after the second pass
    lb = log_addr.size(); db = done_cnt;
    continuous = 1'b1;
    pulse_start();
    for (int n = 0; n < 40 && (log_addr.size() - lb) < 5; n++) tick();
    continuous = 1'b0;
    wait_idle(80);
    chk("cont_words", 32'(log_addr.size() - lb), 8);
    if (log_addr.size() - lb >= 5) begin
      chk("cont_wrap_addr", 32'(log_addr[lb+4]), 0);
      chk("cont_wrap_data", 32'(log_data[lb+4]), 4'h3);
      chk("cont_wrap_gap", 32'(log_cyc[lb+4] - log_cyc[lb+3]), 3);
    end
    chk("cont_done_count", 32'(done_cnt - db), 1);

    // 5a: start while busy is ignored, nothing queued
    lb = log_addr.size(); db = done_cnt;
    ready = 1'b0;
    pulse_start();
    wait_valid(20);
    pulse_start();
    ready = 1'b1;
    wait_idle(60);
    chk("busy_start_words", 32'(log_addr.size() - lb), 4);
    chk("busy_start_done", 32'(done_cnt - db), 1);
    tick(); tick(); tick();
    chk("no_queued_restart", 32'(busy), 0);

    // 5b: reset while showing a word
    ready = 1'b0;
    pulse_start();
    wait_valid(20);
    reset = 1'b1;
    tick();
    chk_all_zero("reset_in_show");
    reset = 1'b0;
    ready = 1'b1;
    tick();
    chk("idle_after_reset", 32'(busy), 0);

    // 6: decode of digit 0
    mem[0] = 4'h0;
    pulse_start();
    tick();
    tick();
    chk("zero_data", 32'(bus.out_data), 0);
    chk("zero_seg", 32'(seg), 8'hBF);
    wait_idle(60);
    chk("final_seg", 32'(seg), 8'h71);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_mem_scan_reader
`default_nettype wire
